// File: rtl/histo_pkg.sv
// -----------------------------------------------------------------------------
// histo_pkg
// Shared constants for the photon histogram logger:
//   - stream word constants (frame header, channel tag, terminator)
//   - FSM state encoding
//   - byte_swap helper used when a bin value is placed on the stream
// No ports (package).
// -----------------------------------------------------------------------------
package histo_pkg;

   localparam logic [15:0] WORD_HEADER = 16'hFEED;
   localparam logic [15:0] WORD_CHAN   = 16'hCA00;
   localparam logic [15:0] WORD_TERMIN = 16'h0FED;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_HEADER = 3'd1;
   localparam logic [2:0] ST_CHAN   = 3'd2;
   localparam logic [2:0] ST_STREAM = 3'd3;
   localparam logic [2:0] ST_TERMIN = 3'd4;

   function automatic logic [15:0] byte_swap(input logic [15:0] w);
      return {w[7:0], w[15:8]};
   endfunction

endpackage

// File: rtl/histo_bin.sv
// -----------------------------------------------------------------------------
// histo_bin
// One histogram bin: saturating live counter plus snapshot register.
// Ports:
//   clk_i       clock
//   reset_ni    asynchronous active-low reset
//   inc_i       count one event at this edge
//   clear_i     zero the live counter (wins over everything else)
//   snap_i      copy the pre-edge live value into the snapshot register
//   snap_clr_i  restart the live counter from zero (plus this edge's event)
//   snap_o      snapshot value
//   at_max_o    live counter is at its saturation value
// -----------------------------------------------------------------------------
module histo_bin
   import histo_pkg::*;
#(
   parameter int BINW = 16
) (
   input  logic            clk_i,
   input  logic            reset_ni,
   input  logic            inc_i,
   input  logic            clear_i,
   input  logic            snap_i,
   input  logic            snap_clr_i,
   output logic [BINW-1:0] snap_o,
   output logic            at_max_o
);

   localparam logic [BINW-1:0] CNT_MAX = '1;

   logic [BINW-1:0] live_q, live_d;
   logic [BINW-1:0] snap_q, snap_d;

   assign at_max_o = (live_q == CNT_MAX);
   assign snap_o   = snap_q;

   // A snapshot-clear still keeps the event arriving on the same edge,
   // so no photon is lost across frames.
   always_comb begin
      live_d = live_q;
      if (clear_i) begin
         live_d = '0;
      end else if (snap_clr_i) begin
         live_d = inc_i ? BINW'(1) : '0;
      end else if (inc_i && !at_max_o) begin
         live_d = live_q + BINW'(1);
      end
   end

   always_comb begin
      snap_d = snap_q;
      if (snap_i) begin
         snap_d = live_q;
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         live_q <= '0;
         snap_q <= '0;
      end else begin
         live_q <= live_d;
         snap_q <= snap_d;
      end
   end

endmodule

// File: rtl/histo_logger.sv
// -----------------------------------------------------------------------------
// histo_logger
// Multi-channel photon arrival histogram with zero-dead-time snapshot and a
// 16-bit framed stream output with backpressure.
// Ports:
//   clk_i      clock
//   reset_ni   asynchronous active-low reset
//   photon_i   latched photon bits, channel c bin b at c*NBINS+b
//   sync_i     accumulate strobe
//   mode_i     0 = clear on snapshot, 1 = cumulative
//   clear_i    synchronous clear of live counters, sat_o, ovr_o
//   start_i    snapshot-and-stream request
//   full_i     downstream full
//   data_o     stream word (0 when wr_o is low)
//   wr_o       stream word valid
//   busy_o     frame in progress
//   sat_o      sticky: a live counter saturated
//   ovr_o      sticky: a start request was dropped while busy
// Frame: FEED, then per channel CA00|c followed by NBINS byte-swapped bins,
// then 0FED.
// -----------------------------------------------------------------------------
module histo_logger
   import histo_pkg::*;
#(
   parameter int NCH   = 2,
   parameter int NBINS = 26,
   parameter int BINW  = 16
) (
   input  logic                 clk_i,
   input  logic                 reset_ni,
   input  logic [NCH*NBINS-1:0] photon_i,
   input  logic                 sync_i,
   input  logic                 mode_i,
   input  logic                 clear_i,
   input  logic                 start_i,
   input  logic                 full_i,
   output logic [15:0]          data_o,
   output logic                 wr_o,
   output logic                 busy_o,
   output logic                 sat_o,
   output logic                 ovr_o
);

   localparam int NW = NCH * NBINS;
   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int BW = $clog2(NBINS);
   localparam int IW = $clog2(NW);

   logic [NW-1:0]   photon_q;
   logic            sync_q;

   logic [2:0]      state_q, state_d;
   logic [CW-1:0]   chan_q, chan_d;
   logic [BW-1:0]   bin_q, bin_d;
   logic [15:0]     data_q, data_d;
   logic            wr_q, wr_d;
   logic            sat_q, sat_d;
   logic            ovr_q, ovr_d;

   logic            snap_take;
   logic            snap_clr;
   logic [BINW-1:0] snap_w [NW];
   logic [NW-1:0]   at_max_w;
   logic [IW-1:0]   sel_idx;
   logic [15:0]     sel_word;

   // Snapshot happens on the accepting edge itself, independent of full_i.
   assign snap_take = start_i && (state_q == ST_IDLE);
   assign snap_clr  = snap_take && !mode_i;

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         photon_q <= '0;
         sync_q   <= 1'b0;
      end else begin
         photon_q <= photon_i;
         sync_q   <= sync_i;
      end
   end

   for (genvar gi = 0; gi < NW; gi++) begin : g_bin
      histo_bin #(
         .BINW (BINW)
      ) u_bin (
         .clk_i      (clk_i),
         .reset_ni   (reset_ni),
         .inc_i      (sync_q & photon_q[gi]),
         .clear_i    (clear_i),
         .snap_i     (snap_take),
         .snap_clr_i (snap_clr),
         .snap_o     (snap_w[gi]),
         .at_max_o   (at_max_w[gi])
      );
   end

   assign sel_idx  = IW'(int'(chan_q) * NBINS + int'(bin_q));
   assign sel_word = byte_swap(16'(snap_w[sel_idx]));

   always_comb begin
      state_d = state_q;
      chan_d  = chan_q;
      bin_d   = bin_q;
      data_d  = '0;
      wr_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_HEADER;
               chan_d  = '0;
               bin_d   = '0;
            end
         end
         ST_HEADER: begin
            if (!full_i) begin
               data_d  = WORD_HEADER;
               wr_d    = 1'b1;
               state_d = ST_CHAN;
            end
         end
         ST_CHAN: begin
            if (!full_i) begin
               data_d  = WORD_CHAN | 16'(chan_q);
               wr_d    = 1'b1;
               bin_d   = '0;
               state_d = ST_STREAM;
            end
         end
         ST_STREAM: begin
            if (!full_i) begin
               data_d = sel_word;
               wr_d   = 1'b1;
               if (bin_q == BW'(NBINS - 1)) begin
                  bin_d = '0;
                  if (chan_q == CW'(NCH - 1)) begin
                     state_d = ST_TERMIN;
                  end else begin
                     chan_d  = chan_q + CW'(1);
                     state_d = ST_CHAN;
                  end
               end else begin
                  bin_d = bin_q + BW'(1);
               end
            end
         end
         ST_TERMIN: begin
            if (!full_i) begin
               data_d  = WORD_TERMIN;
               wr_d    = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Clear wins over a same-cycle saturation or dropped start.
   always_comb begin
      sat_d = sat_q | (|at_max_w);
      ovr_d = ovr_q | (start_i && (state_q != ST_IDLE));
      if (clear_i) begin
         sat_d = 1'b0;
         ovr_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= ST_IDLE;
         chan_q  <= '0;
         bin_q   <= '0;
         data_q  <= '0;
         wr_q    <= 1'b0;
         sat_q   <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         chan_q  <= chan_d;
         bin_q   <= bin_d;
         data_q  <= data_d;
         wr_q    <= wr_d;
         sat_q   <= sat_d;
         ovr_q   <= ovr_d;
      end
   end

   assign data_o = data_q;
   assign wr_o   = wr_q;
   assign busy_o = (state_q != ST_IDLE);
   assign sat_o  = sat_q;
   assign ovr_o  = ovr_q;

endmodule

// File: tb/tb_histo_logger.sv
// -----------------------------------------------------------------------------
// tb_histo_logger
// Two instances share all inputs: dut_a (BINW=16) and dut_b (BINW=4, so it
// saturates at 15). A behavioural counter model pushes each expected frame
// into a per-instance queue when start is accepted; a negedge monitor pops
// and compares every written word.
// -----------------------------------------------------------------------------
module tb_histo_logger;

   localparam int NCH   = 2;
   localparam int NBINS = 4;
   localparam int NW    = NCH * NBINS;
   localparam int FRAME = 2 + NCH * (1 + NBINS);
   localparam int MAX_A = 65535;
   localparam int MAX_B = 15;

   logic          clk;
   logic          reset_n;
   logic [NW-1:0] photon;
   logic          sync;
   logic          mode;
   logic          clear;
   logic          start;
   logic          full;

   logic [15:0]   data_a, data_b;
   logic          wr_a, wr_b, busy_a, busy_b, sat_a, sat_b, ovr_a, ovr_b;

   int            n_checks;
   int            n_fail;

   logic [15:0]   q_a[$];
   logic [15:0]   q_b[$];
   int            cnt_a[NW];
   int            cnt_b[NW];
   logic [NW-1:0] pend;
   int            fcnt_a;
   int            fcnt_b;

   histo_logger #(.NCH(NCH), .NBINS(NBINS), .BINW(16)) dut_a (
      .clk_i(clk), .reset_ni(reset_n), .photon_i(photon), .sync_i(sync),
      .mode_i(mode), .clear_i(clear), .start_i(start), .full_i(full),
      .data_o(data_a), .wr_o(wr_a), .busy_o(busy_a), .sat_o(sat_a), .ovr_o(ovr_a)
   );

   histo_logger #(.NCH(NCH), .NBINS(NBINS), .BINW(4)) dut_b (
      .clk_i(clk), .reset_ni(reset_n), .photon_i(photon), .sync_i(sync),
      .mode_i(mode), .clear_i(clear), .start_i(start), .full_i(full),
      .data_o(data_b), .wr_o(wr_b), .busy_o(busy_b), .sat_o(sat_b), .ovr_o(ovr_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] swap16(input int v);
      logic [15:0] w;
      w = 16'(v);
      return {w[7:0], w[15:8]};
   endfunction

   function automatic void push_frame();
      logic [15:0] w;
      q_a.push_back(16'hFEED);
      q_b.push_back(16'hFEED);
      for (int c = 0; c < NCH; c++) begin
         w = 16'hCA00 | 16'(c);
         q_a.push_back(w);
         q_b.push_back(w);
         for (int b = 0; b < NBINS; b++) begin
            q_a.push_back(swap16(cnt_a[c*NBINS+b]));
            q_b.push_back(swap16(cnt_b[c*NBINS+b]));
         end
      end
      q_a.push_back(16'h0FED);
      q_b.push_back(16'h0FED);
   endfunction

   // Effect of the upcoming rising edge on the model, given current inputs.
   // pend holds the event sampled at the previous edge (one-stage pipeline).
   function automatic void model_edge();
      bit take;
      take = start && (q_a.size() == 0);
      if (take) push_frame();
      for (int i = 0; i < NW; i++) begin
         if (clear) begin
            cnt_a[i] = 0;
            cnt_b[i] = 0;
         end else begin
            if (take && !mode) begin
               cnt_a[i] = 0;
               cnt_b[i] = 0;
            end
            if (pend[i]) begin
               if (cnt_a[i] < MAX_A) cnt_a[i]++;
               if (cnt_b[i] < MAX_B) cnt_b[i]++;
            end
         end
      end
      pend = sync ? photon : '0;
   endfunction

   task automatic step(input logic [NW-1:0] ph, input logic sy, input logic st,
                       input logic cl, input logic fu);
      photon = ph;
      sync   = sy;
      start  = st;
      clear  = cl;
      full   = fu;
      model_edge();
      @(posedge clk);
      #1;
      if (fu) begin
         chk("a_stall_wr", 32'(wr_a), 0);
         chk("b_stall_wr", 32'(wr_b), 0);
      end
      photon = '0;
      sync   = 1'b0;
      start  = 1'b0;
      clear  = 1'b0;
      full   = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step('0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic pulse(input int idx, input int n);
      logic [NW-1:0] m;
      m = '0;
      m[idx] = 1'b1;
      for (int i = 0; i < n; i++) step(m, 1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_start();
      step('0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("busy_after_start", 32'(busy_a), 1);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200 && q_a.size() != 0; i++) idle(1);
      chk("frame_timeout", 32'(q_a.size()), 0);
      idle(1);
      chk("busy_after_frame", 32'(busy_a), 0);
   endtask

   // Scoreboard monitor: one line per transaction written by dut_a.
   always @(negedge clk) begin
      if (!reset_n) begin
         fcnt_a = 0;
         fcnt_b = 0;
      end
      if (wr_a) begin
         if (q_a.size() == 0) begin
            chk("a_unexpected_word", 32'(data_a), 32'hFFFF_FFFF);
         end else begin
            logic [15:0] e;
            e = q_a.pop_front();
            $display("word a: got %h expected %h", data_a, e);
            chk("a_word", 32'(data_a), 32'(e));
            fcnt_a++;
            if (q_a.size() == 0) begin
               chk("a_frame_len", 32'(fcnt_a), FRAME);
               fcnt_a = 0;
            end
         end
      end else begin
         chk("a_idle_data", 32'(data_a), 0);
      end
      if (wr_b) begin
         if (q_b.size() == 0) begin
            chk("b_unexpected_word", 32'(data_b), 32'hFFFF_FFFF);
         end else begin
            logic [15:0] e;
            e = q_b.pop_front();
            chk("b_word", 32'(data_b), 32'(e));
            fcnt_b++;
            if (q_b.size() == 0) begin
               chk("b_frame_len", 32'(fcnt_b), FRAME);
               fcnt_b = 0;
            end
         end
      end else begin
         chk("b_idle_data", 32'(data_b), 0);
      end
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      fcnt_a   = 0;
      fcnt_b   = 0;
      pend     = '0;
      for (int i = 0; i < NW; i++) begin
         cnt_a[i] = 0;
         cnt_b[i] = 0;
      end
      reset_n = 1'b0;
      photon  = '0;
      sync    = 1'b0;
      mode    = 1'b0;
      clear   = 1'b0;
      start   = 1'b0;
      full    = 1'b0;

      #12;
      chk("rst_data", 32'(data_a), 0);
      chk("rst_wr", 32'(wr_a), 0);
      chk("rst_busy", 32'(busy_a), 0);
      chk("rst_sat", 32'(sat_b), 0);
      chk("rst_ovr", 32'(ovr_a), 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic frame: bin(0,1) x5, bin(1,3) x2; photon without sync ignored.
      pulse(1, 5);
      pulse(7, 2);
      step('1, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(1);
      do_start();
      wait_idle();

      // Saturation: 20 events on one bin, dut_b caps at 15.
      pulse(2, 20);
      idle(2);
      chk("b_sat", 32'(sat_b), 1);
      chk("a_no_sat", 32'(sat_a), 0);
      do_start();
      wait_idle();

      // Backpressure: 3-cycle stall in the middle of the STREAM section.
      pulse(5, 3);
      pulse(0, 1);
      idle(1);
      do_start();
      idle(4);
      for (int i = 0; i < 3; i++) step('0, 1'b0, 1'b0, 1'b0, 1'b1);
      wait_idle();

      // Event sampled one cycle before start lands in the following frame.
      step(8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
      do_start();
      wait_idle();
      do_start();
      wait_idle();

      // Cumulative mode: counters keep running through the snapshot.
      mode = 1'b1;
      pulse(3, 2);
      idle(1);
      do_start();
      wait_idle();
      pulse(3, 1);
      idle(1);
      do_start();
      wait_idle();
      mode = 1'b0;

      // Overrun: second start while streaming is dropped and flagged.
      do_start();
      idle(5);
      step('0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("ovr_set_a", 32'(ovr_a), 1);
      chk("ovr_set_b", 32'(ovr_b), 1);
      wait_idle();
      step('0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("ovr_clr", 32'(ovr_a), 0);
      chk("sat_clr", 32'(sat_b), 0);
      idle(1);

      // Reset mid-frame: outputs drop at once, next frame is all zeros.
      pulse(6, 4);
      idle(1);
      do_start();
      idle(5);
      #2;
      reset_n = 1'b0;
      #1;
      chk("mid_rst_wr", 32'(wr_a), 0);
      chk("mid_rst_data", 32'(data_a), 0);
      chk("mid_rst_busy", 32'(busy_a), 0);
      chk("mid_rst_ovr", 32'(ovr_a), 0);
      chk("mid_rst_sat_b", 32'(sat_b), 0);
      q_a.delete();
      q_b.delete();
      pend = '0;
      for (int i = 0; i < NW; i++) begin
         cnt_a[i] = 0;
         cnt_b[i] = 0;
      end
      @(posedge clk);
      #1;
      chk("rst_hold_busy", 32'(busy_b), 0);
      @(posedge clk);
      #3;
      reset_n = 1'b1;
      do_start();
      wait_idle();

      chk("q_a_empty", 32'(q_a.size()), 0);
      chk("q_b_empty", 32'(q_b.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
